// File: rtl/arb_pkg.sv
// Shared encodings and default widths for the program/data memory arbiter.
package arb_pkg;

  localparam int ARB_AW = 5;
  localparam int ARB_DW = 8;
  localparam int WCW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RDATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between CPU and host loader.
// Build option ARB_RR_EN selects round-robin instead of host priority with starvation guard.
module mem_arb_pick
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic           cpu_req,
  input  logic           host_req,
  input  logic [WCW-1:0] wait_cnt,
  input  owner_e         last_owner,
  output owner_e         winner,
  output logic [WCW-1:0] wait_cnt_nxt
);

`ifdef ARB_RR_EN
  logic [WCW-1:0] unused_wait_s;
  assign unused_wait_s = wait_cnt;

  // On contention the side that did not own the memory last time goes next
  always_comb begin
    wait_cnt_nxt = {WCW{1'b0}};
    if (cpu_req && host_req) begin
      winner = (last_owner == OWN_HOST) ? OWN_CPU : OWN_HOST;
    end else if (host_req) begin
      winner = OWN_HOST;
    end else begin
      winner = OWN_CPU;
    end
  end
`else
  localparam logic [WCW-1:0] MAX_W   = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_UP = WCW'(1);

  owner_e unused_owner_s;
  assign unused_owner_s = last_owner;

  // Host wins contention until the CPU has lost MAX_WAIT decisions in a row;
  // the increment only happens below MAX_W, so the count saturates there
  always_comb begin
    winner       = OWN_CPU;
    wait_cnt_nxt = wait_cnt;
    if (cpu_req && host_req) begin
      if (wait_cnt >= MAX_W) begin
        winner       = OWN_CPU;
        wait_cnt_nxt = {WCW{1'b0}};
      end else begin
        winner       = OWN_HOST;
        wait_cnt_nxt = wait_cnt + WAIT_UP;
      end
    end else if (host_req) begin
      winner       = OWN_HOST;
      wait_cnt_nxt = wait_cnt;
    end else begin
      winner       = OWN_CPU;
      wait_cnt_nxt = {WCW{1'b0}};
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port 32x8 memory arbiter between CPU datapath and host loader, registered memory controls.
// Optional build macro ARB_RR_EN (handled inside mem_arb_pick) selects round-robin arbitration.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW       = ARB_AW,
  parameter int DW       = ARB_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_e     state_q, state_d;
  owner_e         owner_q, owner_d, pick_owner_s;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d, pick_wait_s;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           cpu_gnt_q, cpu_gnt_d, host_gnt_q, host_gnt_d;
  logic           cpu_rvalid_q, cpu_rvalid_d, host_rvalid_q, host_rvalid_d;
  logic           mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic           busy_q, busy_d;

  mem_arb_pick #(
    .MAX_WAIT(MAX_WAIT)
  ) u_pick (
    .cpu_req     (cpu_req),
    .host_req    (host_req),
    .wait_cnt    (wait_cnt_q),
    .last_owner  (owner_q),
    .winner      (pick_owner_s),
    .wait_cnt_nxt(pick_wait_s)
  );

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_CPU;
      wait_cnt_q    <= {WCW{1'b0}};
      we_q          <= 1'b0;
      addr_q        <= {AW{1'b0}};
      wdata_q       <= {DW{1'b0}};
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      wait_cnt_q    <= wait_cnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cpu_gnt_q     <= cpu_gnt_d;
      host_gnt_q    <= host_gnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
    end
  end

  // Next state: requests are only looked at in IDLE; the winner's access is captured there
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || host_req) begin
          state_d    = GRANT;
          owner_d    = pick_owner_s;
          wait_cnt_d = pick_wait_s;
          if (pick_owner_s == OWN_HOST) begin
            we_d    = host_we;
            addr_d  = host_addr;
            wdata_d = host_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers take the values that belong to the state being entered
  always_comb begin
    mem_en_d      = (state_d == GRANT);
    mem_we_d      = (state_d == GRANT) && we_d;
    cpu_gnt_d     = (state_d == GRANT) && (owner_d == OWN_CPU);
    host_gnt_d    = (state_d == GRANT) && (owner_d == OWN_HOST);
    cpu_rvalid_d  = (state_d == RDATA) && (owner_d == OWN_CPU);
    host_rvalid_d = (state_d == RDATA) && (owner_d == OWN_HOST);
    busy_d        = (state_d != IDLE);
  end

  assign cpu_gnt     = cpu_gnt_q;
  assign host_gnt    = host_gnt_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = busy_q;

  // The RAM output is already registered, so read data is only steered, never re-registered
  assign cpu_rdata  = cpu_rvalid_q  ? mem_rdata : {DW{1'b0}};
  assign host_rdata = host_rvalid_q ? mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level reference model, RAM model and
// a monitor that checks every DUT cycle. Honours ARB_RR_EN when defined.
module tb_mem_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MAX_WAIT = 4;
  localparam int M_OFF = 0, M_RAND = 1, M_CONT = 2, M_ONE = 3, M_PULSE = 4;

  typedef struct {
    logic          host;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk, rst_n;
  logic req [2];
  logic we [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0] gnt_v;

  int mode [2];
  int one_cnt [2];
  int one_seen [2];
  logic one_we [2];
  logic [AW-1:0] one_addr [2];
  logic [DW-1:0] one_wdata [2];

  exp_t exp_q [$];
  logic win_log [$];
  int ncmp, nfail;

  assign gnt_v = {host_gnt, cpu_gnt};

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(req[1]), .host_we(we[1]), .host_addr(addr[1]), .host_wdata(wdata[1]),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous 32x8 RAM
  initial begin
    logic [DW-1:0] ram [32];
    for (int i = 0; i < 32; i++) ram[i] = '0;
    mem_rdata <= '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Requester drivers (both sides), changing inputs on the falling edge
  initial begin
    logic [31:0] r;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; one_seen[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        r = $urandom;
        if (!rst_n) begin
          req[i] = 1'b0;
        end else begin
          case (mode[i])
            M_RAND: begin
              if (gnt_v[i] || !req[i]) begin
                if (r[31:30] != 2'b00) begin
                  req[i] = 1'b1; we[i] = r[0]; addr[i] = r[5:1]; wdata[i] = r[13:6];
                end else begin
                  req[i] = 1'b0;
                end
              end else if (r[29:26] == 4'd0) begin
                req[i] = 1'b0;
              end
            end
            M_CONT: begin
              if (gnt_v[i] || !req[i]) begin
                req[i] = 1'b1; we[i] = 1'b0; addr[i] = r[5:1]; wdata[i] = r[13:6];
              end
            end
            M_ONE, M_PULSE: begin
              if (one_cnt[i] != one_seen[i]) begin
                req[i] = 1'b1; we[i] = one_we[i]; addr[i] = one_addr[i]; wdata[i] = one_wdata[i];
                one_seen[i] = one_cnt[i];
              end else if (gnt_v[i] || mode[i] == M_PULSE) begin
                req[i] = 1'b0;
              end
            end
            default: req[i] = 1'b0;
          endcase
        end
      end
    end
  end

  // Reference model: at each free decision point, apply the arbitration rule to pending requests
  initial begin
    int busy_left, lost, idx;
    logic last_host, host_wins;
    logic [DW-1:0] mm [32];
    exp_t e;
    busy_left = 0; lost = 0; last_host = 1'b0;
    for (int i = 0; i < 32; i++) mm[i] = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        busy_left = 0; lost = 0; last_host = 1'b0;
        exp_q.delete();
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (req[0] || req[1]) begin
        if (req[0] && req[1]) begin
`ifdef ARB_RR_EN
          host_wins = !last_host;
`else
          host_wins = (lost < MAX_WAIT);
`endif
          if (host_wins) lost = (lost < MAX_WAIT) ? lost + 1 : lost;
          else lost = 0;
        end else begin
          host_wins = req[1];
          if (!host_wins) lost = 0;
        end
        idx = host_wins ? 1 : 0;
        e.host = host_wins; e.we = we[idx]; e.addr = addr[idx];
        e.wdata = wdata[idx]; e.rdata = mm[addr[idx]];
        if (we[idx]) begin
          mm[addr[idx]] = wdata[idx];
          busy_left = 1;
        end else begin
          busy_left = 2;
        end
        last_host = host_wins;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: every cycle, compare DUT outputs against what the scoreboard says is due
  initial begin
    logic rv_due, rv_host, gnt_exp;
    logic [DW-1:0] rv_data;
    logic [1:0] exp_gnt, exp_rv;
    exp_t e;
    rv_due = 1'b0; rv_host = 1'b0; rv_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rv_due = 1'b0;
      end else begin
        gnt_exp = (exp_q.size() != 0);
        exp_gnt = 2'b00;
        if (gnt_exp) exp_gnt = exp_q[0].host ? 2'b10 : 2'b01;
        exp_rv = rv_due ? (rv_host ? 2'b10 : 2'b01) : 2'b00;
        chk("busy", 32'(busy), 32'(gnt_exp || rv_due));
        chk("gnt", 32'(gnt_v), 32'(exp_gnt));
        chk("mem_en", 32'(mem_en), 32'(gnt_exp));
        chk("rvalid", 32'({host_rvalid, cpu_rvalid}), 32'(exp_rv));
        chk("cpu_rdata", 32'(cpu_rdata), 32'((rv_due && !rv_host) ? rv_data : 8'h00));
        chk("host_rdata", 32'(host_rdata), 32'((rv_due && rv_host) ? rv_data : 8'h00));
        rv_due = 1'b0;
        if (gnt_exp) begin
          e = exp_q.pop_front();
          win_log.push_back(host_gnt);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          if (!e.we) begin
            rv_due = 1'b1; rv_host = e.host; rv_data = e.rdata;
          end
        end else begin
          chk("mem_we_idle", 32'(mem_we), 32'd0);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int i);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!gnt_v[i] && k < 40);
    if (!gnt_v[i]) chk("gnt_timeout", 32'(gnt_v[i]), 32'd1);
    #1;
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mode[i] = M_ONE; one_we[i] = w; one_addr[i] = a; one_wdata[i] = d;
    one_cnt[i] = one_cnt[i] + 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int log_start, sz;
    logic exp_host;
    ncmp = 0; nfail = 0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_OFF; one_cnt[i] = 0; one_we[i] = 1'b0; one_addr[i] = '0; one_wdata[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_en, mem_we, busy}), 32'd0);
    chk("rst_bus", 32'({mem_addr, mem_wdata, cpu_rdata, host_rdata}), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_ctl", 32'({cpu_gnt, host_gnt, mem_en, mem_we, busy}), 32'd0);

    issue(1, 1'b1, 5'h03, 8'hA5);
    wait_gnt(1);
    chk("host_wr_we", 32'(mem_we), 32'd1);
    issue(1, 1'b0, 5'h03, 8'h00);
    wait_gnt(1);
    @(negedge clk);
    chk("host_rd_rvalid", 32'(host_rvalid), 32'd1);
    chk("host_rd_data", 32'(host_rdata), 32'hA5);
    cyc(3);

    issue(0, 1'b1, 5'h1F, 8'hFF);
    wait_gnt(0);
    chk("cpu_wr_ctl", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({2'b11, 5'h1F, 8'hFF}));
    cyc(1);
    chk("cpu_wr_after", 32'({mem_en, mem_we, cpu_rvalid, host_rvalid}), 32'd0);
    cyc(3);

    log_start = win_log.size();
    mode[0] = M_CONT; mode[1] = M_CONT;
    cyc(40);
    mode[0] = M_OFF; mode[1] = M_OFF;
    cyc(6);
    chk("contention_count", 32'(win_log.size() >= log_start + 10), 32'd1);
    if (win_log.size() >= log_start + 10) begin
      for (int k = 0; k < 10; k++) begin
`ifdef ARB_RR_EN
        exp_host = (k % 2 == 0);
`else
        exp_host = (k % (MAX_WAIT + 1) != MAX_WAIT);
`endif
        chk("contention_order", 32'(win_log[log_start + k]), 32'(exp_host));
      end
    end

    issue(1, 1'b0, 5'h03, 8'h00);
    wait_gnt(1);
    sz = win_log.size();
    mode[0] = M_PULSE; one_we[0] = 1'b0; one_addr[0] = 5'h07; one_cnt[0] = one_cnt[0] + 1;
    cyc(8);
    chk("pulse_no_gnt", 32'(win_log.size()), 32'(sz));
    mode[0] = M_OFF; mode[1] = M_OFF;
    cyc(2);

    mode[0] = M_RAND; mode[1] = M_RAND;
    cyc(3000);
    mode[0] = M_OFF; mode[1] = M_OFF;
    cyc(6);

    issue(1, 1'b1, 5'h0A, 8'h5C);
    wait_gnt(1);
    rst_n = 1'b0;
    #1;
    chk("rst_in_grant", 32'({mem_we, mem_en, host_gnt, busy}), 32'd0);
    mode[1] = M_OFF;
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_ctl", 32'({cpu_gnt, host_gnt, mem_en, mem_we, busy}), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
